// File: rtl/jar_pi_pkg.sv
// Shared types, pi digit table and index helper for the jar_pi_stream display.
package jar_pi_pkg;

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  // First 256 hex digits of pi, most significant nibble is digit 0 ("3").
  localparam logic [1023:0] PI_HEX = {4'h3, 1020'h243F6A88_85A308D3_13198A2E_03707344_A4093822_299F31D0_082EFA98_EC4E6C89_452821E6_38D01377_BE5466CF_34E90C6C_C0AC29B7_C97C50DD_3F84D5B5_B5470917_9216D5D9_8979FB1B_D1310BA6_98DFB5AC_2FFD72DB_D01ADFB7_B8E1AFED_6A267E96_BA7C9045_F12C7F99_24A19947_B3916CF7_0801F2E2_858EFC16_636920D8_71574E6};

  function automatic logic [7:0] clamp_index(input logic [7:0] i, input int unsigned digits);
    if (32'(i) >= digits) return 8'(digits - 1);
    return i;
  endfunction

endpackage

// File: rtl/jar_pi_rom.sv
// Combinational pi digit lookup: index -> 4-bit hex digit.
module jar_pi_rom
  import jar_pi_pkg::*;
(
  input  logic [7:0] idx,
  output logic [3:0] digit_c
);

  logic [9:0] base;

  always_comb begin
    base    = 10'd1020 - {idx, 2'b00};
    digit_c = PI_HEX[base +: 4];
  end

endmodule

// File: rtl/seg7hex.sv
// Hex to 7-segment decoder, active-high, bit order gfedcba.
module seg7hex (
  input  logic [3:0] hex,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = 7'h00;
    case (hex)
      4'h0: seg_c = 7'h3F;
      4'h1: seg_c = 7'h06;
      4'h2: seg_c = 7'h5B;
      4'h3: seg_c = 7'h4F;
      4'h4: seg_c = 7'h66;
      4'h5: seg_c = 7'h6D;
      4'h6: seg_c = 7'h7D;
      4'h7: seg_c = 7'h07;
      4'h8: seg_c = 7'h7F;
      4'h9: seg_c = 7'h6F;
      4'hA: seg_c = 7'h77;
      4'hB: seg_c = 7'h7C;
      4'hC: seg_c = 7'h39;
      4'hD: seg_c = 7'h5E;
      4'hE: seg_c = 7'h79;
      4'hF: seg_c = 7'h71;
      default: seg_c = 7'h00;
    endcase
  end

endmodule

// File: rtl/jar_pi_stream.sv
// Steps through stored pi hex digits on a 7-seg display (run / step / load, blank gap on repeats).
// Optional macro JAR_PI_DP_EN lights the decimal point while digit 0 ("3.") is shown.
module jar_pi_stream
  import jar_pi_pkg::*;
#(
  parameter int unsigned DIGITS     = 256,
  parameter int unsigned PERIOD     = 1000,
  parameter int unsigned GAP_CYCLES = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       step,
  input  logic       load,
  input  logic [7:0] index_in,
  output logic [7:0] segments,
  output logic [7:0] index_out,
  output logic       wrap
);

  localparam int unsigned PW = $clog2(PERIOD);
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [7:0]    LAST_IDX = 8'(DIGITS - 1);
  localparam logic [PW-1:0] PLAST    = PW'(PERIOD - 1);
  localparam logic [GW-1:0] GLAST    = GW'(GAP_CYCLES - 1);

  state_t        state;
  logic [7:0]    idx;
  logic [PW-1:0] presc;
  logic [GW-1:0] gap_cnt;
  logic [1:0]    run_sync;
  logic [2:0]    step_sync;
  logic [2:0]    load_sync;

  logic [7:0] next_idx_c;
  logic [3:0] cur_digit_c;
  logic [3:0] nxt_digit_c;
  logic [6:0] seg_c;
  logic       dp_c;
  logic       run_s;
  logic       step_edge;
  logic       load_edge;

  assign next_idx_c = (idx == LAST_IDX) ? 8'd0 : idx + 8'd1;
  assign run_s      = run_sync[1];
  assign step_edge  = step_sync[1] & ~step_sync[2];
  assign load_edge  = load_sync[1] & ~load_sync[2];
  assign index_out  = idx;

`ifdef JAR_PI_DP_EN
  assign dp_c = (idx == 8'd0) && (state != GAP);
`else
  assign dp_c = 1'b0;
`endif

  jar_pi_rom u_rom_cur (.idx(idx),        .digit_c(cur_digit_c));
  jar_pi_rom u_rom_nxt (.idx(next_idx_c), .digit_c(nxt_digit_c));
  seg7hex    u_seg     (.hex(cur_digit_c), .seg_c(seg_c));

  // Synchronisers, display register and IDLE/SHOW/GAP sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 8'd0;
      presc     <= '0;
      gap_cnt   <= '0;
      run_sync  <= '0;
      step_sync <= '0;
      load_sync <= '0;
      segments  <= 8'h00;
      wrap      <= 1'b0;
    end else begin
      run_sync  <= {run_sync[0], run};
      step_sync <= {step_sync[1:0], step};
      load_sync <= {load_sync[1:0], load};
      segments  <= (state == GAP) ? 8'h00 : {dp_c, seg_c};
      wrap      <= 1'b0;

      if (load_edge) begin
        idx   <= clamp_index(index_in, DIGITS);
        presc <= '0;
        if (state != IDLE) state <= SHOW;
      end else begin
        unique case (state)
          IDLE: begin
            presc <= '0;
            if (step_edge) begin
              idx  <= next_idx_c;
              wrap <= (next_idx_c == 8'd0);
            end else if (run_s) begin
              state <= SHOW;
            end
          end
          SHOW: begin
            if (presc == PLAST) begin
              presc <= '0;
              if (nxt_digit_c == cur_digit_c) begin
                state   <= GAP;
                gap_cnt <= '0;
              end else begin
                idx  <= next_idx_c;
                wrap <= (next_idx_c == 8'd0);
              end
            end else if (!run_s) begin
              state <= IDLE;
              presc <= '0;
            end else begin
              presc <= presc + PW'(1);
            end
          end
          GAP: begin
            if (gap_cnt == GLAST) begin
              idx   <= next_idx_c;
              wrap  <= (next_idx_c == 8'd0);
              state <= SHOW;
              presc <= '0;
            end else if (!run_s) begin
              state <= IDLE;
            end else begin
              gap_cnt <= gap_cnt + GW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
